// File: rtl/int_adder_tree_accum_seq.sv
// rtl/int_adder_tree_accum_seq.sv - beat issuer and vector accumulator around an external fixed-latency adder tree
module int_adder_tree_accum_seq #(
   parameter int NUM_IN_WORDS     = 4,
   parameter int BITS_PER_IN_WORD = 8,
   parameter int TREE_OUT_BITS    = 10,
   parameter int TREE_LATENCY     = 2,
   parameter int ACC_BITS         = 16,
   parameter int SIGN_EXT         = 1,
   parameter int MAX_BEATS        = 16
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             in_valid,
   output logic                                             in_ready,
   input  logic                                             in_last,
   input  logic [NUM_IN_WORDS-1:0][BITS_PER_IN_WORD-1:0]    in_words,
   output logic [NUM_IN_WORDS-1:0][BITS_PER_IN_WORD-1:0]    tree_words_in,
   output logic                                             tree_extra_bit_in,
   input  logic [TREE_OUT_BITS-1:0]                         tree_sum,
   input  logic                                             tree_extra_bit_out,
   output logic                                             out_valid,
   input  logic                                             out_ready,
   output logic [ACC_BITS-1:0]                              out_sum,
   output logic [$clog2(MAX_BEATS+1)-1:0]                   out_beats,
   output logic                                             busy,
   output logic                                             err_overflow
);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FEED = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]                                    r_state;
   logic [TREE_LATENCY:0]                         r_vld;
   logic [TREE_LATENCY:0]                         r_lst;
   logic [NUM_IN_WORDS-1:0][BITS_PER_IN_WORD-1:0] r_tree_words;
   logic [ACC_BITS-1:0]                           r_acc;
   logic [ACC_BITS-1:0]                           r_out_sum;
   logic                                          r_first;
   logic                                          r_out_valid;
   logic                                          r_err;
   logic [CNT_W-1:0]                              r_in_cnt;
   logic [CNT_W-1:0]                              r_ret_cnt;
   logic [CNT_W-1:0]                              r_out_beats;

   logic                w_slot_ok;
   logic                w_accept;
   logic                w_ret;
   logic                w_ret_last;
   logic                w_sign;
   logic [ACC_BITS-1:0] w_ext;
   logic [ACC_BITS-1:0] w_acc_next;
   logic [CNT_W-1:0]    w_ret_cnt_next;

   // A single result register: a last beat may only issue when its result is guaranteed a free slot.
   assign w_slot_ok  = !(|(r_vld & r_lst)) && (!r_out_valid || out_ready);
   assign in_ready   = !rst && (((r_state == S_HOLD) || in_last) ? w_slot_ok : 1'b1);
   assign w_accept   = in_valid && in_ready;
   assign w_ret      = r_vld[TREE_LATENCY];
   assign w_ret_last = w_ret && tree_extra_bit_out;
   assign w_sign     = (SIGN_EXT != 0) && tree_sum[TREE_OUT_BITS-1];

   if (ACC_BITS > TREE_OUT_BITS) begin : g_ext
      assign w_ext = {{(ACC_BITS-TREE_OUT_BITS){w_sign}}, tree_sum};
   end else begin : g_noext
      assign w_ext = tree_sum;
   end

   assign w_acc_next     = r_first ? w_ext : r_acc + w_ext;
   assign w_ret_cnt_next = r_first ? CNT_W'(1) :
                           (r_ret_cnt == MAX_CNT) ? r_ret_cnt : r_ret_cnt + CNT_W'(1);

   assign tree_words_in     = r_tree_words;
   assign tree_extra_bit_in = r_lst[0];
   assign out_valid         = r_out_valid;
   assign out_sum           = r_out_sum;
   assign out_beats         = r_out_beats;
   assign err_overflow      = r_err;
   assign busy              = !rst && ((|r_vld) || (r_state != S_IDLE));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_vld        <= '0;
         r_lst        <= '0;
         r_tree_words <= '0;
         r_acc        <= '0;
         r_first      <= 1'b1;
         r_in_cnt     <= '0;
         r_ret_cnt    <= '0;
         r_out_valid  <= 1'b0;
         r_out_sum    <= '0;
         r_out_beats  <= '0;
         r_err        <= 1'b0;
      end else begin
         r_tree_words <= w_accept ? in_words : '0;
         r_vld        <= {r_vld[TREE_LATENCY-1:0], w_accept};
         r_lst        <= {r_lst[TREE_LATENCY-1:0], w_accept && in_last};

         case (r_state)
            S_HOLD: begin
               if (w_accept) r_state <= S_IDLE;
            end
            default: begin
               if (w_accept)                 r_state <= in_last ? S_IDLE : S_FEED;
               else if (in_valid && in_last) r_state <= S_HOLD;
            end
         endcase

         // Issue-side beat count detects the overflowing beat as it is accepted.
         if (w_accept) begin
            if (r_in_cnt == MAX_CNT) r_err <= 1'b1;
            if (in_last)                  r_in_cnt <= '0;
            else if (r_in_cnt != MAX_CNT) r_in_cnt <= r_in_cnt + CNT_W'(1);
         end

         if (w_ret) begin
            r_acc     <= w_acc_next;
            r_ret_cnt <= w_ret_cnt_next;
            r_first   <= w_ret_last;
         end

         if (r_out_valid && out_ready) r_out_valid <= 1'b0;
         if (w_ret_last) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_acc_next;
            r_out_beats <= w_ret_cnt_next;
         end
      end
   end
endmodule

// File: tb/tb_int_adder_tree_accum_seq.sv
// tb/tb_int_adder_tree_accum_seq.sv - scoreboard bench for int_adder_tree_accum_seq with behavioural adder trees
module tb_int_adder_tree_accum_seq;
   localparam int TL = 2;
   typedef struct packed { logic [15:0] sum; logic [4:0] beats; } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        v_valid[2], v_ready[2], v_last[2], v_oready[2];
   logic        v_ovalid[2], v_busy[2], v_err[2], v_tx[2];
   logic [31:0] v_words[2], v_twords[2];
   logic [15:0] v_osum[2];
   logic [4:0]  ob0;
   logic [2:0]  ob1;
   logic [9:0]  tp[2][TL];
   logic        tl[2][TL];
   exp_t        q0[$], q1[$];
   int          m_acc[2], m_cnt[2];
   bit          m_ovf[2];
   exp_t        prev[2];
   bit          stall[2];
   int          n_vec = 0, n_err = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int_adder_tree_accum_seq dut0 (
      .clk(clk), .rst(rst), .in_valid(v_valid[0]), .in_ready(v_ready[0]), .in_last(v_last[0]),
      .in_words(v_words[0]), .tree_words_in(v_twords[0]), .tree_extra_bit_in(v_tx[0]),
      .tree_sum(tp[0][TL-1]), .tree_extra_bit_out(tl[0][TL-1]), .out_valid(v_ovalid[0]),
      .out_ready(v_oready[0]), .out_sum(v_osum[0]), .out_beats(ob0), .busy(v_busy[0]),
      .err_overflow(v_err[0]));

   int_adder_tree_accum_seq #(.SIGN_EXT(0), .MAX_BEATS(4)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v_valid[1]), .in_ready(v_ready[1]), .in_last(v_last[1]),
      .in_words(v_words[1]), .tree_words_in(v_twords[1]), .tree_extra_bit_in(v_tx[1]),
      .tree_sum(tp[1][TL-1]), .tree_extra_bit_out(tl[1][TL-1]), .out_valid(v_ovalid[1]),
      .out_ready(v_oready[1]), .out_sum(v_osum[1]), .out_beats(ob1), .busy(v_busy[1]),
      .err_overflow(v_err[1]));

   function automatic int wsum(input logic [31:0] w, input bit sgn);
      int s;
      logic [7:0] b;
      s = 0;
      for (int i = 0; i < 4; i++) begin
         b = w[8*i +: 8];
         s += sgn ? int'($signed(b)) : int'(b);
      end
      return s;
   endfunction

   function automatic logic [4:0] obeats(input int d);
      return (d == 0) ? ob0 : {2'b00, ob1};
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
      end
   endtask

   // Adder trees: sum of the presented words, TL cycles later, with the extra bit riding along.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         tp[d][0] <= 10'(wsum(v_twords[d], d == 0));
         tl[d][0] <= v_tx[d];
         for (int k = 1; k < TL; k++) begin
            tp[d][k] <= tp[d][k-1];
            tl[d][k] <= tl[d][k-1];
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         exp_t o;
         exp_t e;
         o = {v_osum[d], obeats(d)};
         if (stall[d]) begin
            check("hold_valid", v_ovalid[d], 1'b1);
            check("hold_data", o, prev[d]);
         end
         if (v_ovalid[d] && v_oready[d] && !rst) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
               check("unexpected_out", v_ovalid[d], 1'b0);
            end else begin
               if (d == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               check("out_sum", o.sum, e.sum);
               check("out_beats", o.beats, e.beats);
            end
         end
         stall[d] = v_ovalid[d] && !v_oready[d] && !rst;
         prev[d]  = o;
      end
   end

   task automatic send(input int d, input logic [31:0] w, input bit last, output int acc_cyc);
      int n;
      int mb;
      n = 0;
      mb = (d == 0) ? 16 : 4;
      v_valid[d] = 1'b1;
      v_words[d] = w;
      v_last[d]  = last;
      @(negedge clk);
      while (!v_ready[d] && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", n < 200, 1'b1);
      acc_cyc = cyc;
      @(posedge clk);
      if (n < 200) begin
         m_acc[d] += wsum(w, d == 0);
         if (m_cnt[d] == mb) m_ovf[d] = 1'b1;
         else                m_cnt[d]++;
         if (last) begin
            if (d == 0) q0.push_back({16'(m_acc[d]), 5'(m_cnt[d])});
            else        q1.push_back({16'(m_acc[d]), 5'(m_cnt[d])});
            m_acc[d] = 0;
            m_cnt[d] = 0;
         end
      end
      #1;
      v_valid[d] = 1'b0;
      v_last[d]  = 1'b0;
      v_words[d] = '0;
   endtask

   task automatic wait_out(input int d, input logic [15:0] s, input logic [4:0] b);
      int n;
      n = 0;
      while (!v_ovalid[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("wait_out", n < 50, 1'b1);
      check("out_sum_lit", v_osum[d], s);
      check("out_beats_lit", obeats(d), b);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() + q1.size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", q0.size() + q1.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int c, c_prev, n;
      logic [31:0] w;
      for (int d = 0; d < 2; d++) begin
         v_valid[d] = 1'b0; v_last[d] = 1'b0; v_words[d] = '0; v_oready[d] = 1'b1;
         m_acc[d] = 0; m_cnt[d] = 0; m_ovf[d] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_in_ready", v_ready[d], 1'b0);
         check("rst_busy", v_busy[d], 1'b0);
         check("rst_out_valid", v_ovalid[d], 1'b0);
         check("rst_err", v_err[d], 1'b0);
         check("rst_tree_words", v_twords[d], 32'h0);
         check("rst_tree_extra", v_tx[d], 1'b0);
         check("rst_out_sum", v_osum[d], 16'h0);
         check("rst_out_beats", obeats(d), 5'd0);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", v_ready[0], 1'b1);
      @(posedge clk); #1;

      // two-beat vector, latency from last accept
      send(0, 32'h04030201, 1'b0, c);
      send(0, 32'h08070605, 1'b1, c);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!v_ovalid[0] && n < 20);
      check("latency", n, TL + 2);
      check("sum_36", v_osum[0], 16'd36);
      check("beats_2", ob0, 5'd2);
      drain();

      // sign and zero extension
      send(0, 32'hFFFFFFFF, 1'b1, c);
      wait_out(0, 16'hFFFC, 5'd1);
      drain();
      send(1, 32'hFFFFFFFF, 1'b1, c);
      wait_out(1, 16'h03FC, 5'd1);
      drain();

      // backpressure: second last beat stalls until the first result leaves
      v_oready[0] = 1'b0;
      send(0, 32'h01010101, 1'b1, c);
      fork
         send(0, 32'h02020202, 1'b1, c);
         begin
            repeat (8) @(negedge clk);
            check("bp_in_ready", v_ready[0], 1'b0);
            check("bp_busy", v_busy[0], 1'b1);
            check("bp_held_valid", v_ovalid[0], 1'b1);
            check("bp_held_sum", v_osum[0], 16'd4);
            @(posedge clk); #1 v_oready[0] = 1'b1;
            @(posedge clk); #1 v_oready[0] = 1'b0;
            repeat (8) @(negedge clk);
            check("bp_second_valid", v_ovalid[0], 1'b1);
            check("bp_second_sum", v_osum[0], 16'd8);
            @(posedge clk); #1 v_oready[0] = 1'b1;
         end
      join
      drain();

      // overflow on the MAX_BEATS=4 instance
      for (int i = 0; i < 5; i++) begin
         send(1, 32'h01010101, i == 4, c);
         check("ovf_flag", v_err[1], m_ovf[1]);
      end
      check("ovf_sticky", v_err[1], 1'b1);
      wait_out(1, 16'd20, 5'd4);
      drain();

      // reset in the middle of a vector
      send(0, 32'h05050505, 1'b0, c);
      send(0, 32'h06060606, 1'b0, c);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_in_ready", v_ready[0], 1'b0);
      check("mid_rst_busy", v_busy[0], 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_acc[d] = 0; m_cnt[d] = 0; m_ovf[d] = 1'b0;
      end
      @(negedge clk);
      check("mid_rst_ready_after", v_ready[0], 1'b1);
      check("mid_rst_err_clear", v_err[1], 1'b0);
      @(posedge clk); #1;
      send(0, 32'h02020202, 1'b1, c);
      wait_out(0, 16'd8, 5'd1);
      drain();

      // back-to-back single-beat vectors
      c_prev = 0;
      for (int i = 0; i < 8; i++) begin
         w = $urandom;
         send(0, w, 1'b1, c);
         if (i > 0) check("b2b_spacing", c - c_prev, TL + 2);
         c_prev = c;
      end
      drain();

      check("q_empty", q0.size() + q1.size(), 0);
      check("no_err_dut0", v_err[0], 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
